vec_load_store_unit: RTL and testbench

- Services the vector load/store requests issued by the single-threaded pipeline's execution stage.
- Each request is expanded into per-element strided memory accesses.
- Loads: memory data is returned to the vector register file through a response FIFO.
- Stores: each element is read from the register file, then written to memory.
- Sits between the execution stage and the memory fabric and provides the execution stage's busy back-pressure.

---
 rtl/vec_load_store_unit_if.sv | 66 ++++++
 rtl/vec_load_store_unit.sv | 212 +++++++++++++++++++++
 tb/tb_vec_load_store_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_load_store_unit_if.sv
// Execution-stage request, memory fabric and register-file signals of the
// vector load/store unit. master = the unit, slave = its environment.
interface vec_load_store_unit_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int NUM_VREG = 32,
  parameter int MAX_VL   = 64
);
  localparam int VREG_W = $clog2(NUM_VREG);
  localparam int IDX_W  = $clog2(MAX_VL);
  localparam int LEN_W  = IDX_W + 1;

  // execution stage request
  logic              req_vld;
  logic              req_store;
  logic [VREG_W-1:0] req_vreg;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_stride;
  logic [LEN_W-1:0]  req_len;
  logic              busy;
  logic              done;

  // memory fabric
  logic              mem_req_vld;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_req_grant;
  logic              mem_rsp_vld;
  logic [DATA_W-1:0] mem_rsp_data;

  // vector register file
  logic              reg_rd_req;
  logic [VREG_W-1:0] reg_rd_vreg;
  logic [IDX_W-1:0]  reg_rd_idx;
  logic              reg_rd_grant;
  logic              reg_rd_vld;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_wr_vld;
  logic [VREG_W-1:0] reg_wr_vreg;
  logic [IDX_W-1:0]  reg_wr_idx;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_wr_grant;

  modport master (
    input  req_vld, req_store, req_vreg, req_base, req_stride, req_len,
    output busy, done,
    output mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_grant, mem_rsp_vld, mem_rsp_data,
    output reg_rd_req, reg_rd_vreg, reg_rd_idx,
    input  reg_rd_grant, reg_rd_vld, reg_rd_data,
    output reg_wr_vld, reg_wr_vreg, reg_wr_idx, reg_wr_data,
    input  reg_wr_grant
  );

  modport slave (
    output req_vld, req_store, req_vreg, req_base, req_stride, req_len,
    input  busy, done,
    input  mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_grant, mem_rsp_vld, mem_rsp_data,
    input  reg_rd_req, reg_rd_vreg, reg_rd_idx,
    output reg_rd_grant, reg_rd_vld, reg_rd_data,
    input  reg_wr_vld, reg_wr_vreg, reg_wr_idx, reg_wr_data,
    output reg_wr_grant
  );
endinterface

// File: rtl/vec_load_store_unit.sv
// Vector load/store unit: expands a strided vector request into per-element
// memory accesses. Loads stream through a small response FIFO into the
// register file; stores move one element at a time register -> memory.
module vec_load_store_unit #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int NUM_VREG = 32,
  parameter int MAX_VL   = 64,
  parameter int MAX_OUT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vec_load_store_unit_if.master bus
);
  localparam int VREG_W = $clog2(NUM_VREG);
  localparam int IDX_W  = $clog2(MAX_VL);
  localparam int LEN_W  = IDX_W + 1;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [LEN_W-1:0] MAX_VL_C  = LEN_W'(MAX_VL);
  localparam logic [CNT_W:0]   MAX_OUT_C = (CNT_W + 1)'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUT - 1);

  typedef enum logic [2:0] {IDLE, LD_RUN, ST_RD, ST_RDW, ST_WR} state_t;

  state_t            state_q, state_d;
  logic [VREG_W-1:0] vreg_q, vreg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issue_idx_q, issue_idx_d;
  logic [LEN_W-1:0]  wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]  st_idx_q, st_idx_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]  fifo_head_q, fifo_head_d;
  logic [PTR_W-1:0]  fifo_tail_q, fifo_tail_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fifo_mem [MAX_OUT];

  logic [LEN_W-1:0]  req_len_clamped;
  logic [CNT_W:0]    inflight;
  logic              mem_vld, mem_we, rd_req, wr_vld;
  logic              mem_fire, fifo_push, fifo_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: which requests are offered this cycle and which complete.
  always_comb begin
    req_len_clamped = (bus.req_len > MAX_VL_C) ? MAX_VL_C : bus.req_len;
    // Loads may only issue when a FIFO slot is guaranteed for the response.
    inflight = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    mem_vld  = 1'b0;
    mem_we   = 1'b0;
    rd_req   = 1'b0;
    unique case (state_q)
      LD_RUN: mem_vld = (issue_idx_q < len_q) && (inflight < MAX_OUT_C);
      ST_RD:  rd_req = 1'b1;
      ST_WR: begin
        mem_vld = 1'b1;
        mem_we  = 1'b1;
      end
      default: ;
    endcase
    wr_vld    = (state_q == LD_RUN) && (fifo_count_q != '0);
    mem_fire  = mem_vld && bus.mem_req_grant;
    // Responses outside a load, or with nothing outstanding, are dropped.
    fifo_push = (state_q == LD_RUN) && bus.mem_rsp_vld && (outstanding_q != '0);
    fifo_pop  = wr_vld && bus.reg_wr_grant;
  end

  // Next-state logic for the FSM, element counters and response FIFO pointers.
  always_comb begin
    state_d       = state_q;
    vreg_d        = vreg_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    len_d         = len_q;
    issue_idx_d   = issue_idx_q;
    wr_idx_d      = wr_idx_q;
    st_idx_d      = st_idx_q;
    outstanding_d = outstanding_q;
    fifo_count_d  = fifo_count_q;
    fifo_head_d   = fifo_head_q;
    fifo_tail_d   = fifo_tail_q;
    st_data_d     = st_data_q;
    done_d        = 1'b0;

    if (fifo_push) fifo_tail_d = ptr_inc(fifo_tail_q);
    if (fifo_pop)  fifo_head_d = ptr_inc(fifo_head_q);
    if (fifo_push && !fifo_pop)      fifo_count_d = fifo_count_q + CNT_W'(1);
    else if (fifo_pop && !fifo_push) fifo_count_d = fifo_count_q - CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.req_vld) begin
          if (req_len_clamped == '0) begin
            // Empty request completes without ever raising busy.
            done_d = 1'b1;
          end else begin
            vreg_d        = bus.req_vreg;
            addr_d        = bus.req_base;
            stride_d      = bus.req_stride;
            len_d         = req_len_clamped;
            issue_idx_d   = '0;
            wr_idx_d      = '0;
            st_idx_d      = '0;
            outstanding_d = '0;
            state_d       = bus.req_store ? ST_RD : LD_RUN;
          end
        end
      end
      LD_RUN: begin
        if (mem_fire) begin
          issue_idx_d = issue_idx_q + LEN_W'(1);
          addr_d      = addr_q + stride_q;
        end
        if (mem_fire && !fifo_push)      outstanding_d = outstanding_q + CNT_W'(1);
        else if (fifo_push && !mem_fire) outstanding_d = outstanding_q - CNT_W'(1);
        if (fifo_pop) begin
          wr_idx_d = wr_idx_q + LEN_W'(1);
          if (wr_idx_q + LEN_W'(1) == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (bus.reg_rd_grant) state_d = ST_RDW;
      end
      ST_RDW: begin
        if (bus.reg_rd_vld) begin
          st_data_d = bus.reg_rd_data;
          state_d   = ST_WR;
        end
      end
      ST_WR: begin
        if (mem_fire) begin
          st_idx_d = st_idx_q + LEN_W'(1);
          addr_d   = addr_q + stride_q;
          if (st_idx_q + LEN_W'(1) == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any request, flushes the FIFO, no done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      vreg_q        <= '0;
      addr_q        <= '0;
      stride_q      <= '0;
      len_q         <= '0;
      issue_idx_q   <= '0;
      wr_idx_q      <= '0;
      st_idx_q      <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      fifo_head_q   <= '0;
      fifo_tail_q   <= '0;
      st_data_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      vreg_q        <= vreg_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      len_q         <= len_d;
      issue_idx_q   <= issue_idx_d;
      wr_idx_q      <= wr_idx_d;
      st_idx_q      <= st_idx_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      fifo_head_q   <= fifo_head_d;
      fifo_tail_q   <= fifo_tail_d;
      st_data_q     <= st_data_d;
      done_q        <= done_d;
    end
  end

  // Response FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_tail_q] <= bus.mem_rsp_data;
  end

  // Outputs: payload fields are held at zero whenever their valid is low.
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.mem_req_vld   = mem_vld;
  assign bus.mem_req_we    = mem_we;
  assign bus.mem_req_addr  = mem_vld ? addr_q : '0;
  assign bus.mem_req_wdata = mem_we ? st_data_q : '0;
  assign bus.reg_rd_req    = rd_req;
  assign bus.reg_rd_vreg   = rd_req ? vreg_q : '0;
  assign bus.reg_rd_idx    = rd_req ? st_idx_q[IDX_W-1:0] : '0;
  assign bus.reg_wr_vld    = wr_vld;
  assign bus.reg_wr_vreg   = wr_vld ? vreg_q : '0;
  assign bus.reg_wr_idx    = wr_vld ? wr_idx_q[IDX_W-1:0] : '0;
  assign bus.reg_wr_data   = wr_vld ? fifo_mem[fifo_head_q] : '0;
endmodule

// File: tb/tb_vec_load_store_unit.sv
// Directed bench for vec_load_store_unit: a memory/register-file responder
// process logs every handshake; one task per scenario checks the logs.
module tb_vec_load_store_unit;
  localparam int ADDR_W = 32, DATA_W = 64, NUM_VREG = 32, MAX_VL = 64, MAX_OUT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vec_load_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_VREG(NUM_VREG),
                           .MAX_VL(MAX_VL)) bus ();

  vec_load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_VREG(NUM_VREG),
                        .MAX_VL(MAX_VL), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // responder controls
  bit          mem_grant_en = 1'b1;
  bit          wr_grant_en  = 1'b1;
  int          rsp_delay    = 2;
  logic [63:0] ld_data_next = '0;
  int          cyc          = 0;

  // handshake logs
  logic [31:0] log_addr[$];
  bit          log_we[$];
  logic [63:0] log_wdata[$];
  logic [4:0]  log_wvreg[$];
  logic [5:0]  log_widx[$];
  logic [63:0] log_wval[$];
  int          done_cnt = 0;

  int          rsp_due[$];
  logic [63:0] rsp_dat[$];
  bit          rd_pending = 1'b0;
  logic [63:0] rd_pend_data = '0;

  function automatic logic [63:0] rd_model(input logic [4:0] vreg, input logic [5:0] idx);
    return 64'h5A5A_0000_0000_0000 | (64'(vreg) << 16) | 64'(idx);
  endfunction

  // Memory and register-file responder: drive at negedge+2, sample at negedge+3.
  initial begin
    bus.mem_req_grant = 1'b0; bus.mem_rsp_vld = 1'b0; bus.mem_rsp_data = '0;
    bus.reg_rd_grant = 1'b0; bus.reg_rd_vld = 1'b0; bus.reg_rd_data = '0;
    bus.reg_wr_grant = 1'b0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      bus.mem_req_grant = mem_grant_en;
      bus.reg_wr_grant  = wr_grant_en;
      bus.reg_rd_grant  = 1'b1;
      if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
        bus.mem_rsp_vld  = 1'b1;
        bus.mem_rsp_data = rsp_dat[0];
        void'(rsp_due.pop_front());
        void'(rsp_dat.pop_front());
      end else begin
        bus.mem_rsp_vld  = 1'b0;
        bus.mem_rsp_data = '0;
      end
      bus.reg_rd_vld  = rd_pending;
      bus.reg_rd_data = rd_pending ? rd_pend_data : '0;
      rd_pending = 1'b0;
      #1;
      if (bus.mem_req_vld && bus.mem_req_grant) begin
        log_addr.push_back(bus.mem_req_addr);
        log_we.push_back(bus.mem_req_we);
        log_wdata.push_back(bus.mem_req_wdata);
        if (!bus.mem_req_we) begin
          rsp_due.push_back(cyc + rsp_delay);
          rsp_dat.push_back(ld_data_next);
          ld_data_next++;
        end
      end
      if (bus.reg_rd_req && bus.reg_rd_grant) begin
        rd_pending   = 1'b1;
        rd_pend_data = rd_model(bus.reg_rd_vreg, bus.reg_rd_idx);
      end
      if (bus.reg_wr_vld && bus.reg_wr_grant) begin
        log_wvreg.push_back(bus.reg_wr_vreg);
        log_widx.push_back(bus.reg_wr_idx);
        log_wval.push_back(bus.reg_wr_data);
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    log_wvreg.delete(); log_widx.delete(); log_wval.delete();
    done_cnt = 0;
  endtask

  task automatic issue_req(input bit st, input logic [4:0] vreg, input logic [31:0] base,
                           input logic [31:0] stride, input logic [6:0] len);
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_store = st; bus.req_vreg = vreg;
    bus.req_base = base; bus.req_stride = stride; bus.req_len = len;
    @(negedge clk);
    bus.req_vld = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk); #4;
      if (!bus.busy) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #4;
    n_cmp++; if ({bus.busy, bus.done, bus.mem_req_vld, bus.reg_rd_req, bus.reg_wr_vld} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {bus.busy, bus.done, bus.mem_req_vld, bus.reg_rd_req, bus.reg_wr_vld}); end
    n_cmp++; if ({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.reg_wr_data} !== '0) begin
      n_bad++; $display("FAIL reset_data: addr %h wdata %h regwr %h want 0", bus.mem_req_addr, bus.mem_req_wdata, bus.reg_wr_data); end
    reset = 1'b0;
    @(negedge clk); #4;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", bus.busy); end
    $display("reset: outputs idle");
  endtask

  task automatic test_load_basic();
    bit ok;
    clear_logs(); mem_grant_en = 1; wr_grant_en = 1; rsp_delay = 2; ld_data_next = 64'hA0;
    issue_req(1'b0, 5'd5, 32'h1000, 32'd8, 7'd4);
    #4;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL load_busy_rise: got %b want 1", bus.busy); end
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL load_timeout: busy %b want 0", bus.busy); end
    n_cmp++; if (log_addr.size() != 4 || log_wval.size() != 4) begin
      n_bad++; $display("FAIL load_counts: mem %0d wr %0d want 4 4", log_addr.size(), log_wval.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== 32'h1000 + 32'(8 * i) || log_we[i] !== 1'b0) begin
        n_bad++; $display("FAIL load_addr[%0d]: got %h we %b want %h we 0", i, log_addr[i], log_we[i], 32'h1000 + 32'(8 * i)); end
    end
    for (int i = 0; i < 4 && i < log_wval.size(); i++) begin
      n_cmp++; if (log_wvreg[i] !== 5'd5 || log_widx[i] !== 6'(i) || log_wval[i] !== 64'hA0 + 64'(i)) begin
        n_bad++; $display("FAIL load_wr[%0d]: got v%0d i%0d %h want v5 i%0d %h", i, log_wvreg[i], log_widx[i], log_wval[i], i, 64'hA0 + 64'(i)); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL load_done: got %0d want 1", done_cnt); end
    $display("load v5 base 1000 len 4: %0d mem, %0d wr, %0d done", log_addr.size(), log_wval.size(), done_cnt);
  endtask

  task automatic test_load_backpressure();
    bit ok;
    clear_logs(); mem_grant_en = 1; wr_grant_en = 0; rsp_delay = 2; ld_data_next = 64'hB000;
    issue_req(1'b0, 5'd7, 32'h2000, 32'd16, 7'd8);
    repeat (10) @(negedge clk);
    #4;
    n_cmp++; if (log_addr.size() != 4) begin n_bad++; $display("FAIL bp_stall_issues: got %0d want 4", log_addr.size()); end
    n_cmp++; if (bus.busy !== 1'b1 || log_wval.size() != 0) begin
      n_bad++; $display("FAIL bp_stall_state: busy %b wr %0d want 1 0", bus.busy, log_wval.size()); end
    wr_grant_en = 1;
    wait_idle(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout: busy %b want 0", bus.busy); end
    n_cmp++; if (log_addr.size() != 8 || log_wval.size() != 8) begin
      n_bad++; $display("FAIL bp_counts: mem %0d wr %0d want 8 8", log_addr.size(), log_wval.size()); end
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== 32'h2000 + 32'(16 * i)) begin
        n_bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, log_addr[i], 32'h2000 + 32'(16 * i)); end
    end
    for (int i = 0; i < 8 && i < log_wval.size(); i++) begin
      n_cmp++; if (log_wvreg[i] !== 5'd7 || log_widx[i] !== 6'(i) || log_wval[i] !== 64'hB000 + 64'(i)) begin
        n_bad++; $display("FAIL bp_wr[%0d]: got v%0d i%0d %h want v7 i%0d %h", i, log_wvreg[i], log_widx[i], log_wval[i], i, 64'hB000 + 64'(i)); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    $display("load v7 len 8 backpressure: %0d mem, %0d wr, %0d done", log_addr.size(), log_wval.size(), done_cnt);
  endtask

  task automatic test_store_wrap();
    bit ok;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'h0; exp_addr[2] = 32'h8;
    clear_logs(); mem_grant_en = 1; wr_grant_en = 1;
    issue_req(1'b1, 5'd2, 32'hFFFF_FFF8, 32'd8, 7'd3);
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL st_timeout: busy %b want 0", bus.busy); end
    n_cmp++; if (log_addr.size() != 3 || log_wval.size() != 0) begin
      n_bad++; $display("FAIL st_counts: mem %0d regwr %0d want 3 0", log_addr.size(), log_wval.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== exp_addr[i] || log_we[i] !== 1'b1 || log_wdata[i] !== rd_model(5'd2, 6'(i))) begin
        n_bad++; $display("FAIL st_elem[%0d]: got %h we %b %h want %h we 1 %h", i, log_addr[i], log_we[i], log_wdata[i], exp_addr[i], rd_model(5'd2, 6'(i))); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL st_done: got %0d want 1", done_cnt); end
    $display("store v2 base fffffff8 len 3: %0d mem, %0d done", log_addr.size(), done_cnt);
  endtask

  task automatic test_neg_stride();
    bit ok;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h100; exp_addr[1] = 32'hFC; exp_addr[2] = 32'hF8;
    clear_logs(); mem_grant_en = 1; wr_grant_en = 1; ld_data_next = 64'hC0;
    issue_req(1'b0, 5'd1, 32'h100, 32'hFFFF_FFFC, 7'd3);
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL neg_timeout: busy %b want 0", bus.busy); end
    n_cmp++; if (log_addr.size() != 3 || log_wval.size() != 3) begin
      n_bad++; $display("FAIL neg_counts: mem %0d wr %0d want 3 3", log_addr.size(), log_wval.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== exp_addr[i]) begin
        n_bad++; $display("FAIL neg_addr[%0d]: got %h want %h", i, log_addr[i], exp_addr[i]); end
    end
    for (int i = 0; i < 3 && i < log_wval.size(); i++) begin
      n_cmp++; if (log_widx[i] !== 6'(i) || log_wval[i] !== 64'hC0 + 64'(i)) begin
        n_bad++; $display("FAIL neg_wr[%0d]: got i%0d %h want i%0d %h", i, log_widx[i], log_wval[i], i, 64'hC0 + 64'(i)); end
    end
    $display("load v1 base 100 stride -4 len 3: %0d mem, %0d wr", log_addr.size(), log_wval.size());
  endtask

  task automatic test_clamp();
    bit ok;
    clear_logs(); mem_grant_en = 1; wr_grant_en = 1; ld_data_next = 64'h0;
    issue_req(1'b0, 5'd3, 32'h0, 32'd4, 7'd100);
    wait_idle(600, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL clamp_timeout: busy %b want 0", bus.busy); end
    n_cmp++; if (log_addr.size() != 64 || log_wval.size() != 64) begin
      n_bad++; $display("FAIL clamp_counts: mem %0d wr %0d want 64 64", log_addr.size(), log_wval.size()); end
    if (log_addr.size() >= 64 && log_wval.size() >= 64) begin
      n_cmp++; if (log_addr[63] !== 32'd252 || log_widx[63] !== 6'd63 || log_wval[63] !== 64'd63) begin
        n_bad++; $display("FAIL clamp_last: got %h i%0d %h want 000000fc i63 3f", log_addr[63], log_widx[63], log_wval[63]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clamp_done: got %0d want 1", done_cnt); end
    $display("load v3 len 100 clamped: %0d mem, %0d wr", log_addr.size(), log_wval.size());
  endtask

  task automatic test_len_zero_and_busy();
    bit ok;
    clear_logs(); mem_grant_en = 1; wr_grant_en = 1;
    issue_req(1'b0, 5'd4, 32'h3000, 32'd8, 7'd0);
    #4;
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL len0_pulse: done %b busy %b want 1 0", bus.done, bus.busy); end
    @(negedge clk); #4;
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL len0_after: done %b busy %b want 0 0", bus.done, bus.busy); end
    n_cmp++; if (log_addr.size() != 0 || log_wval.size() != 0 || done_cnt != 1) begin
      n_bad++; $display("FAIL len0_traffic: mem %0d wr %0d done %0d want 0 0 1", log_addr.size(), log_wval.size(), done_cnt); end
    $display("load len 0: %0d mem, %0d done", log_addr.size(), done_cnt);

    clear_logs(); wr_grant_en = 0; ld_data_next = 64'hE0;
    issue_req(1'b0, 5'd4, 32'h4000, 32'd8, 7'd2);
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_store = 1'b1; bus.req_base = 32'h5000; bus.req_len = 7'd3;
    repeat (3) @(negedge clk);
    bus.req_vld = 1'b0;
    wr_grant_en = 1;
    wait_idle(100, ok);
    repeat (5) @(negedge clk);
    #4;
    n_cmp++; if (!ok || bus.busy !== 1'b0) begin n_bad++; $display("FAIL busyreq_idle: ok %b busy %b want 1 0", ok, bus.busy); end
    n_cmp++; if (log_addr.size() != 2 || log_wval.size() != 2 || done_cnt != 1) begin
      n_bad++; $display("FAIL busyreq_counts: mem %0d wr %0d done %0d want 2 2 1", log_addr.size(), log_wval.size(), done_cnt); end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== 32'h4000 + 32'(8 * i) || log_we[i] !== 1'b0) begin
        n_bad++; $display("FAIL busyreq_addr[%0d]: got %h we %b want %h we 0", i, log_addr[i], log_we[i], 32'h4000 + 32'(8 * i)); end
    end
    $display("load len 2 with req_vld while busy: %0d mem, %0d done", log_addr.size(), done_cnt);
  endtask

  task automatic test_reset_mid_load();
    clear_logs(); mem_grant_en = 1; wr_grant_en = 1; rsp_delay = 5; ld_data_next = 64'hD0;
    issue_req(1'b0, 5'd6, 32'h6000, 32'd8, 7'd4);
    #4;
    for (int k = 0; k < 20 && log_addr.size() < 2; k++) begin
      @(negedge clk); #4;
    end
    n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL rst_pre_issues: got %0d want 2", log_addr.size()); end
    @(negedge clk);
    reset = 1'b1; mem_grant_en = 0;
    @(negedge clk); #4;
    n_cmp++; if ({bus.busy, bus.mem_req_vld, bus.reg_wr_vld, bus.done} !== 4'b0) begin
      n_bad++; $display("FAIL rst_mid_state: busy/memvld/wrvld/done %b want 0000", {bus.busy, bus.mem_req_vld, bus.reg_wr_vld, bus.done}); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    n_cmp++; if (log_wval.size() != 0 || done_cnt != 0 || log_addr.size() != 2) begin
      n_bad++; $display("FAIL rst_late_rsp: wr %0d done %0d mem %0d want 0 0 2", log_wval.size(), done_cnt, log_addr.size()); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.reg_wr_vld !== 1'b0) begin
      n_bad++; $display("FAIL rst_final: busy %b wrvld %b want 0 0", bus.busy, bus.reg_wr_vld); end
    mem_grant_en = 1; rsp_delay = 2;
    $display("reset mid-load: %0d mem before reset, %0d wr, %0d done", log_addr.size(), log_wval.size(), done_cnt);
  endtask

  initial begin
    bus.req_vld = 1'b0; bus.req_store = 1'b0; bus.req_vreg = '0;
    bus.req_base = '0; bus.req_stride = '0; bus.req_len = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_load_basic();
    test_load_backpressure();
    test_store_wrap();
    test_neg_stride();
    test_clamp();
    test_len_zero_and_busy();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
